qam_mixer_sync: RTL and testbench
=================================

// Module: qam_mixer_sync
// PURPOSE
//  Parametrised I/Q upconversion mixer: qam = I*cos -/+ Q*sin, aligned to carrier zero-crossing.
//  Sits between the shaping filter output and the DAC-side qam stream.
//  Buffers filter samples in an internal FIFO and starts each burst on a carrier zero flag.
//  Adds runtime sideband select, rounding, saturation, overflow detection and a flushable enable.
// PARAMETERS
//  FILTER_WIDTH  10  signed width of filt_i / filt_q
//  CARRIER_WIDTH 8   signed width of car_sin / car_cos (1Q(CW-2) format)
//  QAM_WIDTH     10  signed output width; must satisfy QAM_WIDTH <= FILTER_WIDTH+CARRIER_WIDTH
//  FIFO_DEPTH    64  sample-pair FIFO depth; power of 2, >= 4
//  START_LEVEL   4   FIFO occupancy required before a burst may start; 1..FIFO_DEPTH
// PORTS
//  axi_clk    in   1     system clock; all logic on rising edge
//  axi_rst    in   1     asynchronous reset, active-high
//  en         in   1     block enable; low = flush and idle
//  sb_sel     in   1     0: I*cos - Q*sin; 1: I*cos + Q*sin
//  clr_ovf    in   1     clears sticky ovf
//  filt_valid in   1     filter sample strobe
//  filt_i     in   FW    filter I sample (signed)
//  filt_q     in   FW    filter Q sample (signed)
//  car_sin    in   CW    carrier sine (signed)
//  car_cos    in   CW    carrier cosine (signed)
//  car_zero   in   1     carrier phase-zero pulse
//  qam_valid  out  1     output sample strobe
//  qam_data   out  QW    modulated output (signed)
//  fifo_level out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  ovf        out  1     sticky: a write was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (async, axi_rst=1):
//   - state=IDLE; FIFO empty; pipeline cleared.
//   - qam_valid=0, qam_data=0, fifo_level=0, ovf=0.
//  FIFO:
//   - {filt_i,filt_q} written on filt_valid when en=1.
//   - Write with FIFO full and no same-cycle read: sample dropped, ovf<=1.
//   - Write with FIFO full and a same-cycle read: write accepted, ovf unchanged.
//   - ovf stays set until clr_ovf; clr_ovf and a new overflow in the same cycle: ovf stays 1.
//  FSM:
//   - IDLE -> WAIT_ZERO when en=1.
//   - WAIT_ZERO -> RUN on car_zero=1 with fifo_level>=START_LEVEL; otherwise car_zero is ignored.
//   - RUN: one FIFO read per cycle while not empty.
//   - RUN -> WAIT_ZERO when a cycle starts with the FIFO empty; no read that cycle. The next burst realigns to a later car_zero.
//   - Any state -> IDLE the cycle after en=0. FIFO is flushed, in-flight pipeline samples are discarded, and qam_valid is 0 from that cycle on.
//  Pipeline (read strobe in cycle n):
//   - n+1: FIFO data valid; car_sin, car_cos and sb_sel registered with it.
//   - n+2: products Pi=I*cos and Pq=Q*sin registered, each FW+CW bits signed.
//   - n+3: S = Pi - Pq (sb_sel=0) or Pi + Pq (sb_sel=1), computed at FW+CW+1 bits; no negation of sin, so no most-negative overflow.
//   - n+3: qam_data = sat_QW((S + 2^(K-1)) >>> K), K = FW+CW-QW; round half-up; K=0 means no rounding.
//   - qam_valid=1 in n+3; qam_data holds its value when qam_valid=0.
//  Bursts: fully back-to-back reads give contiguous qam_valid, one sample per clock.
// TESTING
//  - Defaults; START_LEVEL samples of I=256, Q=0, cos=64; pulse car_zero -> qam_data=64 with qam_valid 3 cycles after the first read.
//  - I=0, Q=256, sin=64: sb_sel=0 -> qam_data=-64; sb_sel=1 -> qam_data=+64.
//  - I=-512, cos=-128, Q=511, sin=-128, sb_sel=0 -> S=130944, rounds to 512 -> saturates to qam_data=511.
//  - Write 65 samples with no car_zero -> fifo_level=64, ovf=1; clr_ovf -> ovf=0.
//  - Level 3 <START_LEVEL with car_zero -> no read; 4th write then car_zero -> burst starts.
//  - Drain the FIFO in RUN -> WAIT_ZERO with no reads until the next car_zero.
//  - en=0 mid-burst -> qam_valid=0 the next cycle, fifo_level=0.
//  - axi_rst pulsed mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/qam_mixer_sync.sv
// I/Q upconversion mixer: FIFO-buffered filter samples, burst start aligned to the
// carrier zero pulse, 3-stage multiply / combine / round-saturate pipeline.
module qam_mixer_sync #(
   parameter int FILTER_WIDTH  = 10,
   parameter int CARRIER_WIDTH = 8,
   parameter int QAM_WIDTH     = 10,
   parameter int FIFO_DEPTH    = 64,
   parameter int START_LEVEL   = 4
) (
   input  logic                              axi_clk,
   input  logic                              axi_rst,
   input  logic                              en,
   input  logic                              sb_sel,
   input  logic                              clr_ovf,
   input  logic                              filt_valid,
   input  logic signed [FILTER_WIDTH-1:0]    filt_i,
   input  logic signed [FILTER_WIDTH-1:0]    filt_q,
   input  logic signed [CARRIER_WIDTH-1:0]   car_sin,
   input  logic signed [CARRIER_WIDTH-1:0]   car_cos,
   input  logic                              car_zero,
   output logic                              qam_valid,
   output logic signed [QAM_WIDTH-1:0]       qam_data,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
   output logic                              ovf
);

   localparam int FW = FILTER_WIDTH;
   localparam int CW = CARRIER_WIDTH;
   localparam int QW = QAM_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = FW + CW;
   localparam int XW = PW + 2;   // sum needs PW+1, one more bit absorbs the rounding add
   localparam int K  = PW - QW;

   localparam logic signed [XW-1:0] RND  = XW'((2**K) / 2);
   localparam logic signed [XW-1:0] QMAX = XW'((2**(QW-1)) - 1);
   localparam logic signed [XW-1:0] QMIN = ~QMAX;

   typedef enum logic [1:0] {IDLE, WAIT_ZERO, RUN} state_t;

   state_t state, state_nxt;

   logic [2*FW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            empty, full, rd_en, wr_req, wr_en, ovf_evt;

   logic                  v1, v2;
   logic signed [FW-1:0]  i1, q1;
   logic signed [CW-1:0]  sin1, cos1;
   logic                  sb1, sb2;
   logic signed [PW-1:0]  pi2, pq2;
   logic signed [XW-1:0]  s_ext, s_rnd;
   logic signed [QW-1:0]  s_sat;

   assign fifo_level = wr_ptr - rd_ptr;
   assign empty      = (fifo_level == '0);
   assign full       = (fifo_level == LW'(FIFO_DEPTH));
   assign rd_en      = en && (state == RUN) && !empty;
   assign wr_req     = en && filt_valid;
   assign wr_en      = wr_req && (!full || rd_en);
   assign ovf_evt    = wr_req && full && !rd_en;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = WAIT_ZERO;
         WAIT_ZERO: if (car_zero && (fifo_level >= LW'(START_LEVEL))) state_nxt = RUN;
         RUN:       if (empty) state_nxt = WAIT_ZERO;
         default:   state_nxt = IDLE;
      endcase
      if (!en) state_nxt = IDLE;
   end

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge axi_clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {filt_i, filt_q};
   end

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (!en) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + LW'(1);
         if (rd_en) rd_ptr <= rd_ptr + LW'(1);
      end
   end

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst)      ovf <= 1'b0;
      else if (ovf_evt) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
   end

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         v1   <= 1'b0;
         i1   <= '0;
         q1   <= '0;
         sin1 <= '0;
         cos1 <= '0;
         sb1  <= 1'b0;
      end else begin
         v1 <= rd_en;
         if (rd_en) begin
            {i1, q1} <= mem[rd_ptr[AW-1:0]];
            sin1     <= car_sin;
            cos1     <= car_cos;
            sb1      <= sb_sel;
         end
      end
   end

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         v2  <= 1'b0;
         pi2 <= '0;
         pq2 <= '0;
         sb2 <= 1'b0;
      end else begin
         v2 <= v1 && en;
         if (v1) begin
            pi2 <= PW'(i1) * PW'(cos1);
            pq2 <= PW'(q1) * PW'(sin1);
            sb2 <= sb1;
         end
      end
   end

   // Sideband chosen by add/sub of the product so -sin is never formed.
   always_comb begin
      s_ext = sb2 ? (XW'(pi2) + XW'(pq2)) : (XW'(pi2) - XW'(pq2));
      s_rnd = (s_ext + RND) >>> K;
      s_sat = s_rnd[QW-1:0];
      if (s_rnd > QMAX)      s_sat = QMAX[QW-1:0];
      else if (s_rnd < QMIN) s_sat = QMIN[QW-1:0];
   end

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         qam_valid <= 1'b0;
         qam_data  <= '0;
      end else begin
         qam_valid <= v2 && en;
         if (v2 && en) qam_data <= s_sat;
      end
   end

endmodule

// File: tb/tb_qam_mixer_sync.sv
// Scoreboard bench for qam_mixer_sync: a queue-based behavioural model predicts each
// output sample and its cycle; a negedge monitor compares against the DUT.
module tb_qam_mixer_sync;

   localparam int FW    = 10;
   localparam int CW    = 8;
   localparam int QW    = 10;
   localparam int DEPTH = 64;
   localparam int START = 4;
   localparam int K     = FW + CW - QW;

   logic axi_clk = 1'b0, axi_rst = 1'b1;
   logic en = 1'b0, sb_sel = 1'b0, clr_ovf = 1'b0, filt_valid = 1'b0, car_zero = 1'b0;
   logic signed [FW-1:0] filt_i = '0, filt_q = '0;
   logic signed [CW-1:0] car_sin = '0, car_cos = '0;
   logic                 qam_valid;
   logic signed [QW-1:0] qam_data;
   logic [$clog2(DEPTH):0] fifo_level;
   logic                 ovf;

   always #5 axi_clk = ~axi_clk;

   qam_mixer_sync #(
      .FILTER_WIDTH(FW), .CARRIER_WIDTH(CW), .QAM_WIDTH(QW),
      .FIFO_DEPTH(DEPTH), .START_LEVEL(START)
   ) dut (
      .axi_clk(axi_clk), .axi_rst(axi_rst), .en(en), .sb_sel(sb_sel),
      .clr_ovf(clr_ovf), .filt_valid(filt_valid), .filt_i(filt_i), .filt_q(filt_q),
      .car_sin(car_sin), .car_cos(car_cos), .car_zero(car_zero),
      .qam_valid(qam_valid), .qam_data(qam_data), .fifo_level(fifo_level), .ovf(ovf)
   );

   typedef struct {int due; int val;} exp_t;
   exp_t exp_q[$];
   int   m_fi[$], m_fq[$];
   int   m_mode;          // 0 idle, 1 waiting for zero crossing, 2 bursting
   bit   m_ovf;
   int   cyc = 0;
   int   m_n0, m_pi, m_pq;
   bit   m_rd, m_ev;
   int   last_q = 0;
   int   checks = 0, errors = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int mix(input int i, input int q, input int c, input int s, input bit sb);
      int sum, d, r, lim;
      sum = i * c + (sb ? q * s : -(q * s));
      d   = sum + ((1 << K) / 2);
      r   = d / (1 << K);
      if ((d % (1 << K) != 0) && (d < 0)) r = r - 1;
      lim = 1 << (QW - 1);
      if (r > lim - 1) r = lim - 1;
      if (r < -lim)    r = -lim;
      return r;
   endfunction

   always @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         m_fi.delete(); m_fq.delete(); exp_q.delete();
         m_mode = 0; m_ovf = 1'b0; last_q = 0;
      end else begin
         m_n0 = m_fi.size();
         if (!en) begin
            m_fi.delete(); m_fq.delete(); exp_q.delete();
            m_mode = 0;
            if (clr_ovf) m_ovf = 1'b0;
         end else begin
            m_rd = (m_mode == 2) && (m_n0 > 0);
            if (m_rd) begin
               m_pi = m_fi.pop_front();
               m_pq = m_fq.pop_front();
               exp_q.push_back('{cyc + 3, mix(m_pi, m_pq, int'(car_cos), int'(car_sin), sb_sel)});
            end
            m_ev = 1'b0;
            if (filt_valid) begin
               if (m_n0 < DEPTH || m_rd) begin
                  m_fi.push_back(int'(filt_i));
                  m_fq.push_back(int'(filt_q));
               end else m_ev = 1'b1;
            end
            if (m_ev) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            case (m_mode)
               0: m_mode = 1;
               1: if (car_zero && m_n0 >= START) m_mode = 2;
               default: if (m_n0 == 0) m_mode = 1;
            endcase
         end
         cyc++;
      end
   end

   always @(negedge axi_clk) begin
      if (!axi_rst) begin
         chk("fifo_level", int'(fifo_level), m_fi.size());
         chk("ovf", int'(ovf), int'(m_ovf));
         if (qam_valid) begin
            if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
               checks++; errors++;
               $display("FAIL qam_valid_timing: got qam_valid=1 at cycle %0d, required 0", cyc);
            end else begin
               chk("qam_data", int'(qam_data), exp_q[0].val);
               last_q = exp_q[0].val;
               void'(exp_q.pop_front());
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            checks++; errors++;
            $display("FAIL qam_missing: got qam_valid=0 at cycle %0d, required 1 (value %0d)",
                     cyc, exp_q[0].val);
            void'(exp_q.pop_front());
         end else begin
            chk("qam_hold", int'(qam_data), last_q);
         end
      end
   end

   task automatic drive(input bit fv, input int i, input int q, input int s, input int c,
                        input bit cz, input bit sb);
      @(negedge axi_clk);
      filt_valid = fv; filt_i = FW'(i); filt_q = FW'(q);
      car_sin = CW'(s); car_cos = CW'(c); car_zero = cz; sb_sel = sb;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge axi_clk);
         filt_valid = 1'b0; car_zero = 1'b0; clr_ovf = 1'b0;
      end
   endtask

   task automatic burst4(input int i, input int q, input int s, input int c, input bit sb);
      repeat (START) drive(1'b1, i, q, s, c, 1'b0, sb);
      drive(1'b0, 0, 0, s, c, 1'b1, sb);
      gap(8);
   endtask

   initial begin
      repeat (2) @(negedge axi_clk);
      chk("rst_qam_valid", int'(qam_valid), 0);
      chk("rst_qam_data", int'(qam_data), 0);
      chk("rst_fifo_level", int'(fifo_level), 0);
      chk("rst_ovf", int'(ovf), 0);
      #2 axi_rst = 1'b0;

      @(negedge axi_clk); en = 1'b1;
      burst4(256, 0, 0, 64, 1'b0);
      burst4(0, 256, 64, 0, 1'b0);
      burst4(0, 256, 64, 0, 1'b1);
      burst4(-512, 511, -128, -128, 1'b0);

      repeat (DEPTH + 1) drive(1'b1, int'($urandom_range(0, 1023)) - 512,
                               int'($urandom_range(0, 1023)) - 512, 37, -90, 1'b0, 1'b0);
      gap(1);
      chk("full_level", int'(fifo_level), DEPTH);
      chk("full_ovf", int'(ovf), 1);
      clr_ovf = 1'b1;
      gap(1);
      chk("ovf_cleared", int'(ovf), 0);
      clr_ovf = 1'b1; filt_valid = 1'b1;
      gap(1);
      chk("ovf_clr_vs_set", int'(ovf), 1);
      clr_ovf = 1'b1;
      gap(1);
      drive(1'b1, 100, -100, 50, 60, 1'b1, 1'b1);
      repeat (10) drive(1'b1, int'($urandom_range(0, 1023)) - 512, 7, 50, 60, 1'b0, 1'b1);
      @(negedge axi_clk); en = 1'b0; filt_valid = 1'b0;
      @(negedge axi_clk);
      chk("en_off_valid", int'(qam_valid), 0);
      chk("en_off_level", int'(fifo_level), 0);
      en = 1'b1;

      repeat (START - 1) drive(1'b1, 120, -40, 20, 90, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 20, 90, 1'b1, 1'b0);
      gap(3);
      chk("below_start_level", int'(fifo_level), START - 1);
      drive(1'b1, 120, -40, 20, 90, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 20, 90, 1'b1, 1'b0);
      gap(8);
      chk("burst_drained", int'(fifo_level), 0);
      repeat (5) drive(1'b1, -300, 200, 70, -70, 1'b0, 1'b1);
      gap(5);
      chk("wait_no_reads", int'(fifo_level), 5);
      drive(1'b0, 0, 0, 70, -70, 1'b1, 1'b1);
      gap(10);

      repeat (10) drive(1'b1, 300, 150, 40, 100, 1'b0, 1'b0);
      drive(1'b1, 300, 150, 40, 100, 1'b1, 1'b0);
      gap(5);
      #2 axi_rst = 1'b1;
      #1;
      chk("rst_mid_valid", int'(qam_valid), 0);
      chk("rst_mid_data", int'(qam_data), 0);
      chk("rst_mid_level", int'(fifo_level), 0);
      chk("rst_mid_ovf", int'(ovf), 0);
      @(negedge axi_clk);
      #2 axi_rst = 1'b0;

      for (int ph = 0; ph < 2; ph++) begin
         for (int n = 0; n < 2000; n++) begin
            @(negedge axi_clk);
            en         = ($urandom_range(0, 199) != 0);
            filt_valid = (ph == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) != 0);
            car_zero   = (ph == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
            clr_ovf    = ($urandom_range(0, 49) == 0);
            sb_sel     = 1'($urandom_range(0, 1));
            filt_i     = FW'($urandom);
            filt_q     = FW'($urandom);
            car_sin    = CW'($urandom);
            car_cos    = CW'($urandom);
         end
      end

      en = 1'b1;
      gap(DEPTH + 20);
      drive(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
      gap(DEPTH + 20);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
